// File: rtl/muldiv_pkg.sv
// Shared encodings and defaults for the EX-stage iterative multiply/divide unit.
package muldiv_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } stateE;

endpackage

// File: rtl/muldiv_div_core.sv
// One restoring-division step: shift in the next dividend bit, subtract the divisor
// when it fits, and shift the resulting quotient bit into the low half.
module muldiv_div_core #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] remI,
  input  logic [WIDTH-1:0] quoI,
  input  logic [WIDTH-1:0] divisorI,
  output logic [WIDTH-1:0] remO,
  output logic [WIDTH-1:0] quoO
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diffLo;
  logic             fits;

  // The subtraction only needs its low WIDTH bits: whenever it is taken the true
  // difference is below the divisor, or the divisor is zero and the bits wrap
  // through so the remainder ends up equal to the dividend.
  always_comb begin
    shifted = {remI, quoI[WIDTH-1]};
    fits    = (shifted >= {1'b0, divisorI});
    diffLo  = shifted[WIDTH-1:0] - divisorI;
    remO    = fits ? diffLo : shifted[WIDTH-1:0];
    quoO    = {quoI[WIDTH-2:0], fits};
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative unsigned MUL/DIV, one bit per cycle, stalling the pipeline via busy_o.
// Define MULDIV_DIV_EN to build the divider; without it DIV completes with zero results.
module ex_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic             op_i,
  input  logic [WIDTH-1:0] opa_i,
  input  logic [WIDTH-1:0] opb_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_lo_o,
  output logic [WIDTH-1:0] result_hi_o
);

  // state  | meaning
  // IDLE   | waiting for start_i
  // RUN    | one iteration per cycle, counter counts WIDTH down to 1
  // DONE   | results committed on entry, done_o pulses, may accept a new op

  stateE              stateQ, stateD;
  logic               accept;
  logic               commit;
  logic               opQ;
  logic [WIDTH-1:0]   opbQ;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] accNext;
  logic [2*WIDTH-1:0] mulNext;
  logic [2*WIDTH-1:0] resultNext;
  logic [WIDTH:0]     mulSum;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   resLo, resHi;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) stateQ <= S_IDLE;
    else          stateQ <= stateD;
  end

  always_comb begin
    stateD = stateQ;
    accept = 1'b0;
    commit = 1'b0;
    case (stateQ)
      S_IDLE, S_DONE: begin
        stateD = S_IDLE;
        if (start_i && !flush_i) begin
          accept = 1'b1;
          stateD = S_RUN;
        end
      end
      S_RUN: begin
        if (flush_i) begin
          stateD = S_IDLE;
        end else if (cnt == CNT_W'(1)) begin
          commit = 1'b1;
          stateD = S_DONE;
        end
      end
      default: stateD = S_IDLE;
    endcase
  end

  // Shift-add multiply: low half starts as the multiplier and drains out as the
  // product bits shift in from the top.
  always_comb begin
    mulSum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opbQ} : '0);
    mulNext = {mulSum, acc[WIDTH-1:1]};
  end

`ifdef MULDIV_DIV_EN
  logic [WIDTH-1:0] divRem, divQuo;

  muldiv_div_core #(.WIDTH(WIDTH)) uDivCore (
    .remI     (acc[2*WIDTH-1:WIDTH]),
    .quoI     (acc[WIDTH-1:0]),
    .divisorI (opbQ),
    .remO     (divRem),
    .quoO     (divQuo)
  );

  always_comb begin
    case (opQ)
      OP_MUL:  accNext = mulNext;
      OP_DIV:  accNext = {divRem, divQuo};
      default: accNext = mulNext;
    endcase
    resultNext = accNext;
  end
`else
  always_comb begin
    accNext = mulNext;
    case (opQ)
      OP_MUL:  resultNext = mulNext;
      OP_DIV:  resultNext = '0;
      default: resultNext = '0;
    endcase
  end
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      opQ   <= OP_MUL;
      opbQ  <= '0;
      acc   <= '0;
      cnt   <= '0;
      resLo <= '0;
      resHi <= '0;
    end else begin
      if (accept) begin
        opQ  <= op_i;
        opbQ <= opb_i;
        acc  <= {{WIDTH{1'b0}}, opa_i};
        cnt  <= CNT_W'(WIDTH);
      end else if (stateQ == S_RUN) begin
        acc <= accNext;
        cnt <= cnt - CNT_W'(1);
      end
      if (commit) begin
        resHi <= resultNext[2*WIDTH-1:WIDTH];
        resLo <= resultNext[WIDTH-1:0];
      end
    end
  end

  assign busy_o      = (stateQ == S_RUN);
  assign done_o      = (stateQ == S_DONE);
  assign result_lo_o = resLo;
  assign result_hi_o = resHi;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: stimulus pushes expected results, a monitor
// pops and checks them (value and completion cycle) on every done_o.
module tb_ex_muldiv_unit;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    int           cyc;
    string        name;
  } expT;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         op = 1'b0;
  logic [W-1:0] opa = '0;
  logic [W-1:0] opb = '0;
  logic         flush = 1'b0;
  logic         busy, done;
  logic [W-1:0] resLo, resHi;

  int  cyc = 0;
  int  nVec = 0;
  int  nMiss = 0;
  expT sbQ[$];

`ifdef MULDIV_DIV_EN
  localparam logic [W-1:0] D100_7_LO = 32'd14;
  localparam logic [W-1:0] D100_7_HI = 32'd2;
  localparam logic [W-1:0] D5_0_LO   = 32'hFFFF_FFFF;
  localparam logic [W-1:0] D5_0_HI   = 32'd5;
  localparam logic [W-1:0] D3_10_LO  = 32'd0;
  localparam logic [W-1:0] D3_10_HI  = 32'd3;
`else
  localparam logic [W-1:0] D100_7_LO = 32'd0;
  localparam logic [W-1:0] D100_7_HI = 32'd0;
  localparam logic [W-1:0] D5_0_LO   = 32'd0;
  localparam logic [W-1:0] D5_0_HI   = 32'd0;
  localparam logic [W-1:0] D3_10_LO  = 32'd0;
  localparam logic [W-1:0] D3_10_HI  = 32'd0;
`endif

  ex_muldiv_unit dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .start_i     (start),
    .op_i        (op),
    .opa_i       (opa),
    .opb_i       (opb),
    .flush_i     (flush),
    .busy_o      (busy),
    .done_o      (done),
    .result_lo_o (resLo),
    .result_hi_o (resHi)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nVec++;
    if (act !== exp) begin
      nMiss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done_o must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sbQ.size() == 0) begin
        nVec++;
        nMiss++;
        $display("FAIL stray_done: got done_o=1, expected no completion (cycle %0d)", cyc);
      end else begin
        expT e;
        e = sbQ.pop_front();
        check({e.name, "_lo"}, 64'(resLo), 64'(e.lo));
        check({e.name, "_hi"}, 64'(resHi), 64'(e.hi));
        check({e.name, "_cycle"}, 64'(cyc), 64'(e.cyc));
        check({e.name, "_busy_in_done"}, 64'(busy), 64'd0);
      end
    end
  end

  // Called just after a falling edge; start is held for one sampling edge.
  task automatic issue(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit doPush, input logic [W-1:0] eLo, input logic [W-1:0] eHi,
                       input string name);
    expT e;
    start = 1'b1; op = o; opa = a; opb = b;
    if (doPush) begin
      e.lo = eLo; e.hi = eHi; e.cyc = cyc + 33; e.name = name;
      sbQ.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(input string name, output int busyCnt);
    bit seen;
    seen = 0;
    busyCnt = 0;
    for (int i = 0; i < 60; i++) begin
      if (busy) busyCnt++;
      if (done) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) begin
      nVec++;
      nMiss++;
      $display("FAIL %s_timeout: got no done_o in 60 cycles, expected done_o", name);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish by 100000, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int bc;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_lo", 64'(resLo), 64'd0);
    check("rst_hi", 64'(resHi), 64'd0);

    issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'h0000_0001, 32'hFFFF_FFFE, "mul_max");
    waitDone("mul_max", bc);
    check("mul_max_busy_cycles", 64'(bc), 64'd32);
    @(negedge clk);

    // Reset in the middle of a run clears everything immediately.
    issue(1'b0, 32'd7, 32'd7, 0, '0, '0, "");
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrun_rst_busy", 64'(busy), 64'd0);
    check("midrun_rst_done", 64'(done), 64'd0);
    check("midrun_rst_lo", 64'(resLo), 64'd0);
    check("midrun_rst_hi", 64'(resHi), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("post_rst_busy", 64'(busy), 64'd0);

    issue(1'b0, 32'h1234_5678, 32'h10, 1, 32'h2345_6780, 32'h1, "mul_shift");
    waitDone("mul_shift", bc);
    @(negedge clk);
    issue(1'b0, 32'h8000_0000, 32'd2, 1, 32'h0, 32'h1, "mul_carry");
    waitDone("mul_carry", bc);
    @(negedge clk);
    issue(1'b1, 32'd100, 32'd7, 1, D100_7_LO, D100_7_HI, "div_100_7");
    waitDone("div_100_7", bc);
    check("div_busy_cycles", 64'(bc), 64'd32);
    @(negedge clk);
    issue(1'b1, 32'd5, 32'd0, 1, D5_0_LO, D5_0_HI, "div_by_zero");
    waitDone("div_by_zero", bc);
    @(negedge clk);
    issue(1'b1, 32'd3, 32'd10, 1, D3_10_LO, D3_10_HI, "div_small");
    waitDone("div_small", bc);
    @(negedge clk);

    // Flush: 3*4 completes, 6*7 is squashed at cycle 10 and leaves 12 in place.
    issue(1'b0, 32'd3, 32'd4, 1, 32'd12, 32'd0, "mul_3_4");
    waitDone("mul_3_4", bc);
    @(negedge clk);
    issue(1'b0, 32'd6, 32'd7, 0, '0, '0, "");
    repeat (8) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_lo", 64'(resLo), 64'd12);
    check("flush_hi", 64'(resHi), 64'd0);
    repeat (40) @(negedge clk);

    // Back-to-back with an ignored start pulse during RUN.
    issue(1'b0, 32'd2, 32'd3, 1, 32'd6, 32'd0, "mul_2_3");
    repeat (5) @(negedge clk);
    issue(1'b0, 32'd9, 32'd9, 0, '0, '0, "");
    waitDone("mul_2_3", bc);
    issue(1'b0, 32'd5, 32'd5, 1, 32'd25, 32'd0, "mul_5_5");
    waitDone("mul_5_5", bc);
    check("b2b_busy_cycles", 64'(bc), 64'd32);
    @(negedge clk);

    // start and flush together in IDLE: request dropped.
    start = 1'b1; flush = 1'b1; op = 1'b0; opa = 32'd4; opb = 32'd4;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("start_flush_busy", 64'(busy), 64'd0);
    check("start_flush_lo", 64'(resLo), 64'd25);
    repeat (40) @(negedge clk);

    check("scoreboard_empty", 64'(sbQ.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
    $finish;
  end

endmodule
